fwd_hazard_ctrl: RTL

Forwarding and load-use hazard controller for the 5-stage RISC-V core.
- Tracks destination-register info for the EX, MEM and WB stages in its own shadow pipeline.
- Drives the 2-bit selectors of the two EX-stage 3-to-1 operand muxes (0 = register file, 1 = MEM-stage result, 2 = WB-stage result).
- Asserts a one-cycle stall on load-use hazards and inserts a bubble.
- Sits beside the ID/EX pipeline registers and is driven by decode.

---
 rtl/fwd_hazard_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding and load-use hazard control for the
// 5-stage RISC-V core. It keeps a shadow copy of destination-register info
// for EX, MEM and WB and drives the EX operand-mux selectors. It also drives
// the one-cycle load-use stall and the EX bubble indicator.
//
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle counter
// output (stall_cnt). Without it the port and counter do not exist.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic             ex_bubble
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // A stage produces a forwardable value only for a real, writing,
  // non-x0 instruction.
  function automatic logic writes_rd(input logic             vld,
                                     input logic             we,
                                     input logic [REG_W-1:0] rd);
    return vld & we & (rd != '0);
  endfunction

  // Newest producer wins: MEM before WB, else the register file.
  function automatic logic [1:0] pick_src(input logic             ex_vld,
                                          input logic [REG_W-1:0] rs,
                                          input logic             mem_wr,
                                          input logic [REG_W-1:0] mem_rd,
                                          input logic             wb_wr,
                                          input logic [REG_W-1:0] wb_rd);
    logic [1:0] sel;
    sel = SEL_RF;
    if (ex_vld) begin
      if (mem_wr && (mem_rd == rs))
        sel = SEL_MEM;
      else if (wb_wr && (wb_rd == rs))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  // EX record keeps the load flag for load-use detection. The load flag is
  // not carried past EX because nothing downstream of EX reads it.
  logic             ex_valid_q,  ex_valid_d;
  logic [REG_W-1:0] ex_rs1_q,    ex_rs1_d;
  logic [REG_W-1:0] ex_rs2_q,    ex_rs2_d;
  logic [REG_W-1:0] ex_rd_q,     ex_rd_d;
  logic             ex_we_q,     ex_we_d;
  logic             ex_ld_q,     ex_ld_d;

  logic             mem_valid_q, mem_valid_d;
  logic [REG_W-1:0] mem_rd_q,    mem_rd_d;
  logic             mem_we_q,    mem_we_d;

  logic             wb_valid_q,  wb_valid_d;
  logic [REG_W-1:0] wb_rd_q,     wb_rd_d;
  logic             wb_we_q,     wb_we_d;

  logic             mem_wr;
  logic             wb_wr;
  logic             load_use;

  // Forwarding selectors and load-use stall, purely from the stage records
  // and the decode fields.
  always_comb begin
    mem_wr    = writes_rd(mem_valid_q, mem_we_q, mem_rd_q);
    wb_wr     = writes_rd(wb_valid_q,  wb_we_q,  wb_rd_q);
    fwd_a_sel = pick_src(ex_valid_q, ex_rs1_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    fwd_b_sel = pick_src(ex_valid_q, ex_rs2_q, mem_wr, mem_rd_q, wb_wr, wb_rd_q);
    load_use  = id_valid & ex_valid_q & ex_ld_q & (ex_rd_q != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd_q)) |
                 (id_use_rs2 & (id_rs2 == ex_rd_q)));
    // A taken branch kills the decode instruction, so there is nothing to hold.
    stall     = load_use & ~flush;
    ex_bubble = ~ex_valid_q;
  end

  // Next-state for the shadow pipeline: MEM/WB always advance; EX accepts
  // decode only when it is real, not stalled and not flushed.
  always_comb begin
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_we_d    = ex_we_q;
    wb_valid_d  = mem_valid_q;
    wb_rd_d     = mem_rd_q;
    wb_we_d     = mem_we_q;
    ex_valid_d  = 1'b0;
    ex_rs1_d    = '0;
    ex_rs2_d    = '0;
    ex_rd_d     = '0;
    ex_we_d     = 1'b0;
    ex_ld_d     = 1'b0;
    if (id_valid && !stall && !flush) begin
      ex_valid_d = 1'b1;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_rd_d    = id_rd;
      ex_we_d    = id_reg_write;
      ex_ld_d    = id_mem_read;
    end
  end

  // Stage record registers; reset discards every in-flight record.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
